// File: rtl/memory_access_pkg.sv
// Shared types for the memory stage: FSM states, MEM/WB bundle, helpers.
// No ports; imported by the memory stage files.
package memory_access_pkg;

   typedef enum logic {
      MEM_ST_IDLE = 1'b0,
      MEM_ST_WAIT = 1'b1
   } mem_state_e;

   localparam int CNT_W = 8;

   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] mem_data;
      logic [4:0]  reg_dst;
      logic        mem_to_reg;
      logic        reg_wr_en;
   } mem_wb_t;

   function automatic logic is_misaligned(
      input logic [31:0] addr
   );
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory request/ready bus between the memory stage and data memory.
// master: req/we/addr/wdata out, ready/rdata in; slave: the reverse.
interface memory_access_if;

   logic        o_dmem_req;
   logic        o_dmem_we;
   logic [31:0] o_dmem_addr;
   logic [31:0] o_dmem_wdata;
   logic        i_dmem_ready;
   logic [31:0] i_dmem_rdata;

   modport master (
      output o_dmem_req,
      output o_dmem_we,
      output o_dmem_addr,
      output o_dmem_wdata,
      input  i_dmem_ready,
      input  i_dmem_rdata
   );

   modport slave (
      input  o_dmem_req,
      input  o_dmem_we,
      input  o_dmem_addr,
      input  o_dmem_wdata,
      output i_dmem_ready,
      output i_dmem_rdata
   );

endinterface

// File: rtl/memory_access.sv
// RV32I memory stage: branch resolve, word load/store with bounded wait,
// MEM/WB register. Ports: EX/MEM inputs, dmem bus, stall, MEM/WB, errors.
module memory_access
   import memory_access_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           i_pipe_AluResult,
   input  logic [31:0]           i_pipe_Reg2Data,
   input  logic [31:0]           i_pipe_TargetAddr,
   input  logic                  i_pipe_Zero,
   input  logic [4:0]            i_pipe_RegDst,
   input  logic                  i_pipe_MemToReg,
   input  logic                  i_pipe_RegWrEn,
   input  logic                  i_pipe_MemWrEn,
   input  logic                  i_pipe_Branch,
   input  logic                  i_pipe_Jump,
   output logic                  o_pipe_stall,
   output logic                  o_PcSrc,
   output logic [31:0]           o_TargetAddr,
   memory_access_if.master       dmem,
   output logic [31:0]           o_pipe_AluResult,
   output logic [31:0]           o_pipe_MemData,
   output logic [4:0]            o_pipe_RegDst,
   output logic                  o_pipe_MemToReg,
   output logic                  o_pipe_RegWrEn,
   output logic                  o_MisalignErr,
   output logic                  o_BusErr
);

   mem_state_e       state;
   logic [CNT_W-1:0] wait_cnt;
   mem_wb_t          mem_wb;

   logic mem_op;
   logic misalign;
   logic in_wait;
   logic req;
   logic abort;
   logic done;
   logic c_misalign;

   assign mem_op   = i_pipe_MemToReg | i_pipe_MemWrEn;
   assign misalign = is_misaligned(i_pipe_AluResult);
   assign in_wait  = (state == MEM_ST_WAIT);

   // Reset kills the request immediately, dropping any access in flight.
   always_comb begin
      req = 1'b0;
      if (reset) begin
         req = in_wait | (mem_op & ~misalign);
      end
   end

   assign abort = in_wait & ~dmem.i_dmem_ready
                & (wait_cnt == CNT_W'(MAX_WAIT - 1));
   assign done  = req & dmem.i_dmem_ready;
   assign c_misalign = ~in_wait & mem_op & misalign;

   assign o_pipe_stall = req & ~dmem.i_dmem_ready & ~abort;

   assign o_PcSrc      = (i_pipe_Branch & i_pipe_Zero) | i_pipe_Jump;
   assign o_TargetAddr = i_pipe_TargetAddr;

   assign dmem.o_dmem_req   = req;
   assign dmem.o_dmem_we    = i_pipe_MemWrEn;
   assign dmem.o_dmem_addr  = i_pipe_AluResult;
   assign dmem.o_dmem_wdata = i_pipe_Reg2Data;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= MEM_ST_IDLE;
         wait_cnt      <= '0;
         mem_wb        <= '0;
         o_MisalignErr <= 1'b0;
         o_BusErr      <= 1'b0;
      end else begin
         o_MisalignErr       <= 1'b0;
         o_BusErr            <= 1'b0;
         mem_wb.alu_result   <= i_pipe_AluResult;
         mem_wb.mem_data     <= '0;
         mem_wb.reg_dst      <= i_pipe_RegDst;
         mem_wb.mem_to_reg   <= i_pipe_MemToReg;
         mem_wb.reg_wr_en    <= i_pipe_RegWrEn;
         unique case (1'b1)
            c_misalign: begin
               mem_wb.reg_wr_en <= 1'b0;
               o_MisalignErr    <= 1'b1;
            end
            done: begin
               if (i_pipe_MemToReg) begin
                  mem_wb.mem_data <= dmem.i_dmem_rdata;
               end
               state <= MEM_ST_IDLE;
            end
            abort: begin
               mem_wb.reg_wr_en <= 1'b0;
               o_BusErr         <= 1'b1;
               state            <= MEM_ST_IDLE;
            end
            o_pipe_stall: begin
               // Bubble into write-back while the access is pending.
               mem_wb.reg_wr_en  <= 1'b0;
               mem_wb.mem_to_reg <= 1'b0;
               if (in_wait) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end else begin
                  wait_cnt <= '0;
                  state    <= MEM_ST_WAIT;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_pipe_AluResult = mem_wb.alu_result;
   assign o_pipe_MemData   = mem_wb.mem_data;
   assign o_pipe_RegDst    = mem_wb.reg_dst;
   assign o_pipe_MemToReg  = mem_wb.mem_to_reg;
   assign o_pipe_RegWrEn   = mem_wb.reg_wr_en;

endmodule
